// File: rtl/alu_adder_control_pkg.sv
// Shared definitions for the alu_adder_control slice: the FSM state enum,
// the sixteen instruction opcodes (instruction[31:28]) and the ALU
// operation codes that are carried between the control unit and the ALU.
package alu_adder_control_pkg;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

  // Instruction opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_ANDI = 4'h9;
  localparam logic [3:0] OP_ORI  = 4'hA;
  localparam logic [3:0] OP_LUI  = 4'hB;
  localparam logic [3:0] OP_LW   = 4'hC;
  localparam logic [3:0] OP_SW   = 4'hD;
  localparam logic [3:0] OP_BEQ  = 4'hE;
  localparam logic [3:0] OP_JAL  = 4'hF;

  // ALU operation codes; 9-15 are unused and yield zero
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_LUI = 4'd8;

endpackage

// File: rtl/alu_adder_control_adder.sv
// PC adder: sum = a + b modulo 2^32, carry discarded. Stateless.
// Ports: a, b (32-bit operands), sum (32-bit result).
module alu_adder_control_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_adder_control_alu.sv
// Combinational ALU selected by a 4-bit operation code. Stateless.
// Ports: a, b (32-bit operands), code (ALU operation), result (32-bit).
module alu_adder_control_alu
  import alu_adder_control_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  code,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (code)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
      ALU_LUI: result = {b[15:0], 16'b0};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_adder_control_ctrl.sv
// Two-state FETCH/EXECUTE sequencer plus instruction decoder.
// The state register toggles every clock; all strobes and mux selects are
// decoded combinationally from the state, the opcode and (for BEQ) Eq.
// Ports: clk, rst (sync active-low), opcode, Eq in; state, control strobes
// and the ALU operation code out.
module alu_adder_control_ctrl
  import alu_adder_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       Eq,
  output logic       state,
  output logic       instruction_flag,
  output logic       pc_flag,
  output logic       change_address_flag,
  output logic       Wr_en,
  output logic       Wr_en_rf,
  output logic       M13,
  output logic       M2,
  output logic       M457,
  output logic       M6,
  output logic [3:0] ALU
);

  state_t state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= (state_q == FETCH) ? EXECUTE : FETCH;
    end
  end

  assign state = state_q;

  always_comb begin
    instruction_flag    = 1'b0;
    pc_flag             = 1'b0;
    change_address_flag = 1'b0;
    Wr_en               = 1'b0;
    Wr_en_rf            = 1'b0;
    M13                 = 1'b0;
    M2                  = 1'b0;
    M457                = 1'b0;
    M6                  = 1'b0;
    ALU                 = ALU_ADD;
    if (state_q == FETCH) begin
      instruction_flag = 1'b1;
    end else begin
      pc_flag = 1'b1;
      case (opcode)
        // R-type opcodes share their encoding with the ALU codes
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
          M457     = 1'b1;
          Wr_en_rf = 1'b1;
          ALU      = opcode;
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
          M457     = 1'b1;
          M6       = 1'b1;
          Wr_en_rf = 1'b1;
          case (opcode)
            OP_ANDI: ALU = ALU_AND;
            OP_ORI:  ALU = ALU_OR;
            OP_LUI:  ALU = ALU_LUI;
            default: ALU = ALU_ADD;
          endcase
        end
        OP_LW: begin
          change_address_flag = 1'b1;
          Wr_en_rf            = 1'b1;
        end
        OP_SW: begin
          change_address_flag = 1'b1;
          Wr_en               = 1'b1;
        end
        // taken branch selects the offset into the PC adder
        OP_BEQ: M2 = Eq;
        OP_JAL: begin
          M13      = 1'b1;
          Wr_en_rf = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_adder_control.sv
// Top of the adder / ALU / control slice; wires the three sub-blocks.
// The ALU code produced by the control unit drives the ALU datapath and is
// also exported on the ALU port.
// Ports: clk, rst (sync active-low), opcode, Eq, add_a/add_b, alu_a/alu_b in;
// add_out, alu_out, state, control strobes and ALU out.
module alu_adder_control
  import alu_adder_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        Eq,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [31:0] add_out,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_out,
  output logic        state,
  output logic        instruction_flag,
  output logic        pc_flag,
  output logic        change_address_flag,
  output logic        Wr_en,
  output logic        Wr_en_rf,
  output logic        M13,
  output logic        M2,
  output logic        M457,
  output logic        M6,
  output logic [3:0]  ALU
);

  alu_adder_control_adder u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_out)
  );

  alu_adder_control_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .code   (ALU),
    .result (alu_out)
  );

  alu_adder_control_ctrl u_ctrl (
    .clk                 (clk),
    .rst                 (rst),
    .opcode              (opcode),
    .Eq                  (Eq),
    .state               (state),
    .instruction_flag    (instruction_flag),
    .pc_flag             (pc_flag),
    .change_address_flag (change_address_flag),
    .Wr_en               (Wr_en),
    .Wr_en_rf            (Wr_en_rf),
    .M13                 (M13),
    .M2                  (M2),
    .M457                (M457),
    .M6                  (M6),
    .ALU                 (ALU)
  );

endmodule

// File: tb/tb_alu_adder_control.sv
// Bench for alu_adder_control: a behavioural model checked every cycle at the
// falling edge, plus hand-computed literal expectations.
module tb_alu_adder_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic        Eq;
  logic [31:0] add_a, add_b, add_out;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        state;
  logic        instruction_flag, pc_flag, change_address_flag;
  logic        Wr_en, Wr_en_rf, M13, M2, M457, M6;
  logic [3:0]  ALU;

  // standalone ALU so codes the decoder never emits (9-15) can be exercised
  logic [31:0] ua, ub, uout;
  logic [3:0]  ucode;

  int vectors = 0;
  int miscompares = 0;
  logic run = 1'b0;
  logic m_valid = 1'b0;
  logic m_state;
  logic [12:0] exp_c;
  logic [12:0] dut_ctrl;

  always #5 clk = ~clk;

  alu_adder_control dut (
    .clk                 (clk),
    .rst                 (rst),
    .opcode              (opcode),
    .Eq                  (Eq),
    .add_a               (add_a),
    .add_b               (add_b),
    .add_out             (add_out),
    .alu_a               (alu_a),
    .alu_b               (alu_b),
    .alu_out             (alu_out),
    .state               (state),
    .instruction_flag    (instruction_flag),
    .pc_flag             (pc_flag),
    .change_address_flag (change_address_flag),
    .Wr_en               (Wr_en),
    .Wr_en_rf            (Wr_en_rf),
    .M13                 (M13),
    .M2                  (M2),
    .M457                (M457),
    .M6                  (M6),
    .ALU                 (ALU)
  );

  alu_adder_control_alu u_alu_unit (
    .a      (ua),
    .b      (ub),
    .code   (ucode),
    .result (uout)
  );

  assign dut_ctrl = {instruction_flag, pc_flag, change_address_flag, Wr_en,
                     Wr_en_rf, M13, M2, M457, M6, ALU};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (code)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return (sa < sb) ? 32'd1 : 32'd0;
      4'd8: return b * 32'h10000;
      default: return 32'd0;
    endcase
  endfunction

  // {instruction_flag, pc_flag, change_address_flag, Wr_en, Wr_en_rf, M13, M2, M457, M6, ALU}
  function automatic logic [12:0] ctrl_model(input logic st, input logic [3:0] op, input logic eq);
    logic ifl, pcf, caf, we, werf, m13, m2, m457, m6;
    logic [3:0] code;
    {ifl, pcf, caf, we, werf, m13, m2, m457, m6} = '0;
    code = 4'd0;
    if (!st) begin
      ifl = 1'b1;
    end else begin
      pcf = 1'b1;
      if (op < 4'd8) begin
        m457 = 1'b1; werf = 1'b1; code = op;
      end else if (op < 4'd12) begin
        m457 = 1'b1; m6 = 1'b1; werf = 1'b1;
        code = (op == 4'd8) ? 4'd0 : (op == 4'd9) ? 4'd2 : (op == 4'd10) ? 4'd3 : 4'd8;
      end else if (op == 4'd12) begin
        caf = 1'b1; werf = 1'b1;
      end else if (op == 4'd13) begin
        caf = 1'b1; we = 1'b1;
      end else if (op == 4'd14) begin
        m2 = eq;
      end else begin
        m13 = 1'b1; werf = 1'b1;
      end
    end
    return {ifl, pcf, caf, we, werf, m13, m2, m457, m6, code};
  endfunction

  // reference state: reset forces FETCH, otherwise toggle
  always @(posedge clk) begin
    if (!rst) begin
      m_state <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_state <= ~m_state;
    end
  end

  always @(negedge clk) begin
    if (run && m_valid) begin
      exp_c = ctrl_model(m_state, opcode, Eq);
      chk("model_state", {31'b0, state}, {31'b0, m_state});
      chk("model_ctrl", {19'b0, dut_ctrl}, {19'b0, exp_c});
      chk("model_add", add_out, add_a + add_b);
      chk("model_alu", alu_out, alu_model(exp_c[3:0], alu_a, alu_b));
      chk("model_alu_unit", uout, alu_model(ucode, ua, ub));
      chk("wr_exclusive", {31'b0, Wr_en & Wr_en_rf}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; opcode = 4'h0; Eq = 1'b0;
    add_a = '0; add_b = '0; alu_a = '0; alu_b = '0;
    ua = '0; ub = '0; ucode = 4'd0;
    run = 1'b1;

    // reset held for one edge
    step();
    chk("reset_state", {31'b0, state}, 32'd0);
    chk("reset_iflag", {31'b0, instruction_flag}, 32'd1);
    chk("reset_pcflag", {31'b0, pc_flag}, 32'd0);
    chk("reset_alu", {28'b0, ALU}, 32'd0);

    // adder and standalone ALU literals (reset still held: stays FETCH)
    add_a = 32'hFFFF_FFFC; add_b = 32'h4; #1;
    chk("add_wrap", add_out, 32'h0000_0000);
    step();
    add_a = 32'h100; add_b = 32'hFFFF_FFF8; #1;
    chk("add_neg", add_out, 32'h0000_00F8);
    chk("reset_hold_state", {31'b0, state}, 32'd0);
    ucode = 4'd1; ua = 32'd3; ub = 32'd5; #1;
    chk("alu_sub", uout, 32'hFFFF_FFFE);
    step();
    ucode = 4'd7; ua = 32'hFFFF_FFFF; ub = 32'd1; #1;
    chk("alu_slt", uout, 32'd1);
    ucode = 4'd6; ua = 32'h8000_0000; ub = 32'd31; #1;
    chk("alu_srl", uout, 32'd1);
    step();
    ucode = 4'd8; ua = 32'hDEAD_BEEF; ub = 32'h1234; #1;
    chk("alu_lui", uout, 32'h1234_0000);
    ucode = 4'd12; ua = 32'hFFFF_FFFF; ub = 32'hFFFF_FFFF; #1;
    chk("alu_code12", uout, 32'd0);

    // release: next edge enters EXECUTE, with ORI decoded
    rst = 1'b1; opcode = 4'hA; alu_a = 32'hF0; alu_b = 32'h0F;
    step();
    chk("exec_state", {31'b0, state}, 32'd1);
    chk("exec_pcflag", {31'b0, pc_flag}, 32'd1);
    chk("ori_m6", {31'b0, M6}, 32'd1);
    chk("ori_m457", {31'b0, M457}, 32'd1);
    chk("ori_alu", {28'b0, ALU}, 32'd3);
    chk("ori_wrrf", {31'b0, Wr_en_rf}, 32'd1);
    chk("ori_alu_out", alu_out, 32'hFF);
    step();
    chk("ori_back_fetch", {31'b0, state}, 32'd0);

    // BEQ taken / not taken
    opcode = 4'hE; Eq = 1'b1;
    step();
    chk("beq_eq1_m2", {31'b0, M2}, 32'd1);
    chk("beq_eq1_wr", {30'b0, Wr_en, Wr_en_rf}, 32'd0);
    Eq = 1'b0; #1;
    chk("beq_eq0_m2", {31'b0, M2}, 32'd0);
    chk("beq_eq0_wr", {30'b0, Wr_en, Wr_en_rf}, 32'd0);

    // SW
    step();
    opcode = 4'hD;
    step();
    chk("sw_wren", {31'b0, Wr_en}, 32'd1);
    chk("sw_caf", {31'b0, change_address_flag}, 32'd1);
    chk("sw_m457", {31'b0, M457}, 32'd0);

    // JAL
    step();
    opcode = 4'hF;
    step();
    chk("jal_m13", {31'b0, M13}, 32'd1);
    chk("jal_wrrf", {31'b0, Wr_en_rf}, 32'd1);

    // SUB through the top-level ALU path
    step();
    opcode = 4'h1; alu_a = 32'd3; alu_b = 32'd5;
    step();
    chk("top_sub", alu_out, 32'hFFFF_FFFE);

    // reset asserted mid-EXECUTE acts only at the next edge
    rst = 1'b0; #1;
    chk("rst_mid_exec_sync", {31'b0, state}, 32'd1);
    step();
    chk("rst_mid_exec_fetch", {31'b0, state}, 32'd0);
    chk("rst_mid_exec_iflag", {31'b0, instruction_flag}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_release_exec", {31'b0, state}, 32'd1);

    // sweep every opcode with both Eq values in both states
    for (int i = 0; i < 64; i++) begin
      opcode = i[5:2]; Eq = i[1];
      alu_a = $urandom; alu_b = $urandom; add_a = $urandom; add_b = $urandom;
      ucode = i[3:0]; ua = $urandom; ub = $urandom;
      step();
    end

    // random traffic with occasional resets
    for (int i = 0; i < 80; i++) begin
      rst = ($urandom_range(0, 9) != 0);
      opcode = 4'($urandom_range(0, 15)); Eq = 1'($urandom_range(0, 1));
      alu_a = $urandom; alu_b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      add_a = $urandom; add_b = $urandom;
      ucode = 4'($urandom_range(0, 15)); ua = $urandom; ub = $urandom;
      step();
    end

    @(negedge clk);
    #1;
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
